// File: rtl/tx_uart.sv
// ---------------------------------------------------------------------------
// tx_uart - 8N1 serial transmitter with selectable baud rate
//
// Sends one start bit (0), eight data bits LSB first and one stop bit (1).
// Each bit lasts CLK_FREQ/baud clocks, rounded to the nearest integer. The
// byte and the baud selection are captured when a frame is accepted, so
// later input changes only affect the next frame.
//
// Parameters
//   CLK_FREQ  input clock frequency in Hz (default 50 MHz)
//
// Ports
//   clk       system clock, rising edge active
//   rst_n     asynchronous reset, ACTIVE-HIGH despite the name
//   start     transmit request, sampled on the rising edge while idle
//   baud_sel  baud-rate select: 000=4800 001=19200 010=38400 011=57600
//                               100=9600 101=115200 110=230400 111=9600
//   data      byte to transmit
//   ready     high when idle and able to accept start (always ~busy)
//   tx        registered serial output, idles high
//   busy      high while a frame is being sent
// ---------------------------------------------------------------------------
module tx_uart #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] baud_sel,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    // Bit period in clocks, rounded to nearest.
    function automatic int bit_div(input int baud);
        return (CLK_FREQ + baud / 2) / baud;
    endfunction

    localparam int DIV_4800   = bit_div(4800);
    localparam int DIV_9600   = bit_div(9600);
    localparam int DIV_19200  = bit_div(19200);
    localparam int DIV_38400  = bit_div(38400);
    localparam int DIV_57600  = bit_div(57600);
    localparam int DIV_115200 = bit_div(115200);
    localparam int DIV_230400 = bit_div(230400);

    // 4800 baud gives the longest bit period; size the counter for it.
    localparam int CNT_W = $clog2(DIV_4800 + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic             r_busy;

    logic [CNT_W-1:0] w_div;
    logic             w_bit_end;

    // NOTE: every signal assigned in always_comb gets a default before the
    // case, otherwise an uncovered path would infer a latch.
    always_comb begin
        w_div = CNT_W'(DIV_9600);
        case (baud_sel)
            3'b000:  w_div = CNT_W'(DIV_4800);
            3'b001:  w_div = CNT_W'(DIV_19200);
            3'b010:  w_div = CNT_W'(DIV_38400);
            3'b011:  w_div = CNT_W'(DIV_57600);
            3'b100:  w_div = CNT_W'(DIV_9600);
            3'b101:  w_div = CNT_W'(DIV_115200);
            3'b110:  w_div = CNT_W'(DIV_230400);
            default: w_div = CNT_W'(DIV_9600);
        endcase
    end

    // Last clock of the current bit period.
    assign w_bit_end = (r_baud_cnt == r_div - 1'b1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shift    <= data;
                        r_div      <= w_div;
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_START;
                    end
                end

                S_START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_tx       <= r_shift[0];
                        r_state    <= S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            // Present the next bit and shift in the same edge
                            // so tx only ever changes on a bit boundary.
                            r_tx      <= r_shift[1];
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end

                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx    = r_tx;
    assign busy  = r_busy;
    assign ready = ~r_busy;

endmodule

// File: tb/tb_tx_uart.sv
// ---------------------------------------------------------------------------
// tb_tx_uart - self-checking bench for tx_uart
//
// A frame-level model predicts tx/busy/ready on every clock from the time a
// frame was accepted, its bit period and its 10-bit frame. Directed tests
// additionally pin exact frame lengths and bit patterns with literals.
// ---------------------------------------------------------------------------
module tb_tx_uart;

    localparam int CLK_FREQ = 50_000_000;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       start    = 1'b0;
    logic [2:0] baud_sel = 3'b000;
    logic [7:0] data     = 8'h00;
    logic       ready;
    logic       tx;
    logic       busy;

    int total = 0;
    int bad   = 0;

    tx_uart #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .baud_sel (baud_sel),
        .data     (data),
        .ready    (ready),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int div_of(input logic [2:0] sel);
        int baud;
        case (sel)
            3'b000:  baud = 4800;
            3'b001:  baud = 19200;
            3'b010:  baud = 38400;
            3'b011:  baud = 57600;
            3'b100:  baud = 9600;
            3'b101:  baud = 115200;
            3'b110:  baud = 230400;
            default: baud = 9600;
        endcase
        return (CLK_FREQ + baud / 2) / baud;
    endfunction

    int         m_e      = 0;      // index of the most recent rising edge
    int         m_t0     = 0;      // edge at which the current frame was accepted
    int         m_div    = 1;
    logic       m_active = 1'b0;
    logic [9:0] m_frame  = 10'h3FF; // bit i is the line level during bit period i

    always @(posedge clk) m_e <= m_e + 1;

    // A start is taken when the previous frame's final edge lies strictly behind.
    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            m_active <= 1'b0;
        end else if (start && (!m_active || (m_e + 1 - m_t0 > 10 * m_div))) begin
            m_active <= 1'b1;
            m_t0     <= m_e + 1;
            m_div    <= div_of(baud_sel);
            m_frame  <= {1'b1, data, 1'b0};
        end
    end

    always @(negedge clk) begin
        int   k;
        logic eb;
        logic et;
        k  = m_e - m_t0;
        eb = m_active && (k < 10 * m_div);
        et = eb ? m_frame[k / m_div] : 1'b1;
        check("cycle", {29'b0, tx, busy, ready}, {29'b0, et, eb, ~eb});
    end

    // ---------------- directed helpers ----------------
    task automatic send(input logic [2:0] sel, input logic [7:0] byte_v);
        @(negedge clk);
        baud_sel = sel;
        data     = byte_v;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Entered on the first negedge after acceptance; returns on the first
    // negedge with busy low.
    task automatic measure_frame(input string name, input int div,
                                 input logic [9:0] exp_bits, input bit inject);
        int         cnt;
        logic [9:0] got;
        cnt = 0;
        got = '0;
        while (busy === 1'b1 && cnt < 10 * div + 20) begin
            if ((cnt % div == div / 2) && (cnt / div < 10)) got[cnt / div] = tx;
            if (inject) begin
                case (cnt)
                    500:  begin start = 1'b1; data = 8'hFF; baud_sel = 3'b000; end
                    501:  start = 1'b0;
                    1500: begin start = 1'b1; data = 8'h00; baud_sel = 3'b101; end
                    1503: start = 1'b0;
                    default: ;
                endcase
            end
            cnt++;
            @(negedge clk);
        end
        check({name, "_len"}, cnt, 10 * div);
        check({name, "_bits"}, {22'b0, got}, {22'b0, exp_bits});
    endtask

    task automatic count_gap(input string name);
        int g;
        g = 0;
        while (busy !== 1'b1 && g < 10) begin
            g++;
            @(negedge clk);
        end
        check(name, g, 1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with start high: outputs idle, start ignored.
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", ready, 1);
        start = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);

        // 9600 baud, 0x55
        send(3'b100, 8'h55);
        measure_frame("f9600_55", 5208, 10'b1010101010, 1'b0);
        repeat (3) @(negedge clk);
        check("f9600_ready", ready, 1);

        // 38400 baud, 0xAA
        send(3'b010, 8'hAA);
        measure_frame("f38400_AA", 1302, 10'b1101010100, 1'b0);

        // 57600 baud, 0xEF
        send(3'b011, 8'hEF);
        measure_frame("f57600_EF", 868, 10'b1111011110, 1'b0);

        // 230400 baud, 0x3C with start pulses and input changes mid-frame
        send(3'b110, 8'h3C);
        measure_frame("midchg_3C", 217, 10'b1001111000, 1'b1);
        repeat (20) @(negedge clk);
        check("midchg_no_second", busy, 0);

        // Reset during data bit 3 of 0x96 (frame bit 4)
        send(3'b110, 8'h96);
        repeat (949) @(negedge clk);
        check("mid_bit3_tx", tx, 0);
        #2;
        rst_n = 1'b1;
        start = 1'b1;
        #1;
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        check("abort_ready", ready, 1);
        repeat (3) @(negedge clk);
        check("abort_start_ignored", busy, 0);
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("post_abort_idle", busy, 0);

        // 115200 baud, start held for three frames; data changes mid-run
        baud_sel = 3'b101;
        data     = 8'h5A;
        start    = 1'b1;
        @(negedge clk);
        measure_frame("b2b1", 434, 10'b1010110100, 1'b0);
        count_gap("b2b_gap1");
        data = 8'hC3;
        measure_frame("b2b2", 434, 10'b1010110100, 1'b0);
        count_gap("b2b_gap2");
        measure_frame("b2b3", 434, 10'b1110000110, 1'b0);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("b2b_end_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
